// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-32 integer core: FETCH/DECODE/EXEC/MEM/WB over one shared
// ALU, with instruction and data traffic on a single valid/ready memory port.
module mc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  OUT_REG1 = 5'd2,
  parameter logic [4:0]  OUT_REG2 = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] output1,
  output logic [31:0] output2
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  typedef enum logic [3:0] {
    K_NOP  = 4'd0,
    K_ALU  = 4'd1,
    K_LW   = 4'd2,
    K_SW   = 4'd3,
    K_BEQ  = 4'd4,
    K_BNE  = 4'd5,
    K_J    = 4'd6,
    K_JAL  = 4'd7,
    K_JR   = 4'd8,
    K_JALR = 4'd9
  } kind_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] mdr;
  logic [31:0] alu_out;
  logic [31:0] target;
  logic [31:0] rf [32];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  kind_t       kind;
  alu_op_t     dec_op;
  logic        use_imm;
  logic        zext;
  logic        use_shamt;
  logic [4:0]  wb_idx;
  logic [31:0] ext_imm;

  alu_op_t     alu_op;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        taken;
  logic [31:0] exec_next_pc;
  logic [31:0] wb_data;

  function automatic logic [31:0] alu_fn(input alu_op_t op, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_NOR:  r = ~(x | y);
      ALU_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      ALU_SLL:  r = y << x[4:0];
      ALU_SRL:  r = y >> x[4:0];
      ALU_SRA:  r = $signed(y) >>> x[4:0];
      ALU_LUI:  r = {y[15:0], 16'h0000};
      default:  r = x + y;
    endcase
    return r;
  endfunction

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  assign ext_imm = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

  // Instruction decode: operation class, ALU function, operand sources, write index
  always_comb begin
    kind      = K_NOP;
    dec_op    = ALU_ADD;
    use_imm   = 1'b0;
    zext      = 1'b0;
    use_shamt = 1'b0;
    wb_idx    = rd;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin kind = K_ALU; dec_op = ALU_ADD;  end
          6'h22, 6'h23: begin kind = K_ALU; dec_op = ALU_SUB;  end
          6'h24:        begin kind = K_ALU; dec_op = ALU_AND;  end
          6'h25:        begin kind = K_ALU; dec_op = ALU_OR;   end
          6'h26:        begin kind = K_ALU; dec_op = ALU_XOR;  end
          6'h27:        begin kind = K_ALU; dec_op = ALU_NOR;  end
          6'h2a:        begin kind = K_ALU; dec_op = ALU_SLT;  end
          6'h2b:        begin kind = K_ALU; dec_op = ALU_SLTU; end
          6'h00:        begin kind = K_ALU; dec_op = ALU_SLL; use_shamt = 1'b1; end
          6'h02:        begin kind = K_ALU; dec_op = ALU_SRL; use_shamt = 1'b1; end
          6'h03:        begin kind = K_ALU; dec_op = ALU_SRA; use_shamt = 1'b1; end
          6'h08:        kind = K_JR;
          6'h09:        kind = K_JALR;
          default:      kind = K_NOP;
        endcase
      end
      6'h08, 6'h09: begin kind = K_ALU; dec_op = ALU_ADD;  use_imm = 1'b1; wb_idx = rt; end
      6'h0c: begin kind = K_ALU; dec_op = ALU_AND;  use_imm = 1'b1; zext = 1'b1; wb_idx = rt; end
      6'h0d: begin kind = K_ALU; dec_op = ALU_OR;   use_imm = 1'b1; zext = 1'b1; wb_idx = rt; end
      6'h0a: begin kind = K_ALU; dec_op = ALU_SLT;  use_imm = 1'b1; wb_idx = rt; end
      6'h0b: begin kind = K_ALU; dec_op = ALU_SLTU; use_imm = 1'b1; wb_idx = rt; end
      6'h0f: begin kind = K_ALU; dec_op = ALU_LUI;  use_imm = 1'b1; wb_idx = rt; end
      6'h23: begin kind = K_LW;  dec_op = ALU_ADD;  use_imm = 1'b1; wb_idx = rt; end
      6'h2b: begin kind = K_SW;  dec_op = ALU_ADD;  use_imm = 1'b1; end
      6'h04: begin kind = K_BEQ; dec_op = ALU_SUB; end
      6'h05: begin kind = K_BNE; dec_op = ALU_SUB; end
      6'h02: kind = K_J;
      6'h03: begin kind = K_JAL; wb_idx = 5'd31; end
      default: kind = K_NOP;
    endcase
  end

  // Shared ALU operand select: PC+4 in FETCH, branch target in DECODE, datapath in EXEC
  always_comb begin
    alu_op = ALU_ADD;
    alu_x  = pc;
    alu_y  = 32'd4;
    case (state)
      S_FETCH: begin
        alu_x = pc;
        alu_y = 32'd4;
      end
      S_DECODE: begin
        alu_x = pc;
        alu_y = {{14{imm[15]}}, imm, 2'b00};
      end
      S_EXEC: begin
        alu_op = dec_op;
        alu_x  = use_shamt ? {27'd0, shamt} : a;
        alu_y  = use_imm ? ext_imm : b;
      end
      default: begin
        alu_x = pc;
        alu_y = 32'd4;
      end
    endcase
  end

  assign alu_res  = alu_fn(alu_op, alu_x, alu_y);
  assign alu_zero = (alu_res == 32'd0);
  assign taken    = (kind == K_BEQ) ? alu_zero : ~alu_zero;

  // Program counter chosen at the end of EXEC
  always_comb begin
    exec_next_pc = pc;
    case (kind)
      K_BEQ, K_BNE: begin
        if (taken) exec_next_pc = target;
        else       exec_next_pc = pc;
      end
      K_J, K_JAL:   exec_next_pc = {pc[31:28], ir[25:0], 2'b00};
      K_JR, K_JALR: exec_next_pc = a;
      default:      exec_next_pc = pc;
    endcase
  end

  // Loads write back the memory word, everything else the latched result
  always_comb begin
    if (kind == K_LW) wb_data = mdr;
    else              wb_data = alu_out;
  end

  // Control FSM with registered memory-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      mdr       <= 32'd0;
      alu_out   <= 32'd0;
      target    <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          // Coming out of reset the request is not yet up; raise it first.
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= pc & ALIGN_MASK;
            mem_wdata <= 32'd0;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata;
            pc      <= alu_res;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a      <= rf[rs];
          b      <= rf[rt];
          target <= alu_res;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          case (kind)
            K_ALU: begin
              alu_out <= alu_res;
              state   <= S_WB;
            end
            K_LW, K_SW: begin
              alu_out   <= alu_res;
              mem_req   <= 1'b1;
              mem_we    <= (kind == K_SW);
              mem_addr  <= alu_res & ALIGN_MASK;
              mem_wdata <= (kind == K_SW) ? b : 32'd0;
              state     <= S_MEM;
            end
            K_JAL, K_JALR: begin
              alu_out <= pc;
              pc      <= exec_next_pc;
              state   <= S_WB;
            end
            default: begin
              pc        <= exec_next_pc;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= exec_next_pc & ALIGN_MASK;
              mem_wdata <= 32'd0;
              state     <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_we) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= pc & ALIGN_MASK;
              mem_wdata <= 32'd0;
              state     <= S_FETCH;
            end else begin
              mem_req <= 1'b0;
              mdr     <= mem_rdata;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= pc & ALIGN_MASK;
          mem_wdata <= 32'd0;
          state     <= S_FETCH;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_FETCH;
        end
      endcase
    end
  end

  // Register file: written only in WB, $0 never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (state == S_WB && wb_idx != 5'd0) begin
      rf[wb_idx] <= wb_data;
    end
  end

  assign output1 = rf[OUT_REG1];
  assign output2 = rf[OUT_REG2];

endmodule
